button_int_ctrl: RTL and testbench
==================================

// Module: button_int_ctrl
// PURPOSE
//  Interrupt controller between the four board buttons and the CPU pipeline. It synchronises
//  and debounces each button, then latches each press as pending. It arbitrates pending
//  presses by fixed priority and presents one vectored request at a time. The CPU uses its
//  int_ack / int_ret handshake to mark entry to and exit from each service routine.
// PARAMETERS
//  DB_W             16       width of each per-button debounce counter
//  DEBOUNCE_CYCLES  16'd50000  consecutive stable cycles needed to accept a level change (>=1, < 2**DB_W)
//  VEC_BASE         16'h0f80   vector of the highest-priority button (btn 3)
//  VEC_STRIDE       16'h0020   vector spacing between adjacent priorities
// PORTS
//  clk         in   1   system clock; single clock domain
//  rst         in   1   synchronous, active-high reset
//  btn_raw     in   4   raw button levels, active high, asynchronous to clk
//  int_mask    in   4   per-button enable, 1 = may be requested
//  int_ack     in   1   CPU took the vector (1-cycle pulse, same cycle as branch)
//  int_ret     in   1   CPU executed RET from service routine (1-cycle pulse)
//  int_req     out  1   interrupt request to CPU
//  int_vec     out  16  branch target for current request
//  int_id      out  2   button number being requested/serviced
//  in_service  out  1   CPU is inside a service routine
//  pending     out  4   latched, not yet acknowledged presses
// BEHAVIOUR
//  Reset (rst sampled high at posedge): int_req=0, int_vec=0, int_id=0, in_service=0,
//   pending=0, sync flops=0, debounced levels=0, counters=0, FSM=IDLE. Any operation in progress is abandoned.
//  Sync: 2-flop synchroniser per bit, s2 = btn_raw delayed 2 cycles.
//  Debounce, per bit:
//   - s2==db_level: cnt<=0.
//   - Otherwise cnt++.
//   - When cnt==DEBOUNCE_CYCLES-1 and s2 still differs: db_level<=s2, cnt<=0.
//  Pending: pending[i] is set on the edge where db_level[i] goes 0->1.
//   - pending[i] is set regardless of int_mask.
//   - pending[i] is cleared only by int_ack while int_id==i.
//   - If set and clear coincide, set wins.
//   - Repeat presses of a pending button merge; they are not counted.
//  Eligible = pending & int_mask. Priority is fixed: bit 3 highest, bit 0 lowest.
//  FSM (registered outputs):
//   IDLE:
//    - When |eligible: latch int_id = highest eligible bit.
//    - Set int_vec = VEC_BASE + (3-int_id)*VEC_STRIDE, i.e. 0f80/0fa0/0fc0/0fe0 for btn 3/2/1/0.
//    - Set int_req=1 and go to REQ.
//   REQ:
//    - int_req=1; int_vec and int_id are held stable.
//    - The request is never withdrawn; mask changes are ignored until ack.
//    - A higher-priority press arriving here does not pre-empt it.
//    - On int_ack: int_req=0, in_service=1, clear pending[int_id], go to SERVICE.
//   SERVICE:
//    - in_service=1; int_id is held; no new request is issued.
//    - On int_ret: in_service=0, go to IDLE.
//    - A new request can assert on the next edge at the earliest (one cycle in IDLE).
//  Ignored inputs: int_ack outside REQ; int_ret outside SERVICE.
//   If int_ack and int_ret arrive in the same cycle, only the one valid for the current state acts.
//  Latency: btn_raw rises and holds, FSM in IDLE, mask bit set -> int_req=1 exactly
//   DEBOUNCE_CYCLES+3 cycles after the first posedge that samples the new level.
//  Glitches shorter than DEBOUNCE_CYCLES cycles (after sync) never change db_level.
//  Releases (1->0) are debounced identically but generate no event.
//  Arithmetic: int_vec is computed modulo 2**16; (3-int_id) is a 2-bit unsigned value.
// TESTING
//  1. DEBOUNCE_CYCLES=4. Hold btn_raw=4'b0010 from cycle 0 -> int_req=1 at cycle 7,
//     int_vec=16'h0fc0, int_id=1, pending=4'b0010.
//  2. 3-cycle pulse on btn_raw[0], DEBOUNCE_CYCLES=4 -> pending stays 0 and int_req stays 0.
//  3. btn 0 and btn 3 pressed in the same cycle -> first request has int_vec=16'h0f80.
//     After int_ack and int_ret, second request has int_vec=16'h0fe0. pending ends at 0.
//  4. In SERVICE, press btn 2 -> pending[2]=1 and int_req stays 0.
//     After int_ret, int_req asserts on the following edge with vec 16'h0fa0.
//  5. int_mask=4'b1110, press btn 0 -> pending=4'b0001 and no request.
//     Set int_mask[0]=1 -> request with vec 16'h0fe0 next cycle.
//  6. rst asserted while in REQ, and again while in SERVICE -> next cycle all outputs are 0
//     and pending=0. int_ack/int_ret pulses in IDLE have no effect.

Source files
------------

// File: rtl/button_int_ctrl.sv
// Button interrupt controller: sync + debounce four buttons, latch presses as pending,
// and present one fixed-priority vectored request at a time to the CPU.
module button_int_ctrl #(
  parameter int                 DB_W            = 16,
  parameter int unsigned        DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [15:0]        VEC_BASE        = 16'h0f80,
  parameter logic [15:0]        VEC_STRIDE      = 16'h0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  btn_raw,
  input  logic [3:0]  int_mask,
  input  logic        int_ack,
  input  logic        int_ret,
  output logic        int_req,
  output logic [15:0] int_vec,
  output logic [1:0]  int_id,
  output logic        in_service,
  output logic [3:0]  pending
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] CNT_ONE = DB_W'(1);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  logic [3:0]      btn_s1, btn_s2;
  logic [3:0]      db_level, db_prev;
  logic [DB_W-1:0] db_cnt [4];

  state_t          state, state_nxt;
  logic            req_nxt, svc_nxt;
  logic [1:0]      id_nxt;
  logic [15:0]     vec_nxt;
  logic [3:0]      eligible, clr, press;

  // Highest set bit wins; bit 3 is top priority.
  function automatic logic [1:0] top_bit(input logic [3:0] v);
    casez (v)
      4'b1???: top_bit = 2'd3;
      4'b01??: top_bit = 2'd2;
      4'b001?: top_bit = 2'd1;
      default: top_bit = 2'd0;
    endcase
  endfunction

  // Rank is a 2-bit distance from btn 3, so the vector wraps modulo 2**16.
  function automatic logic [15:0] vec_of(input logic [1:0] id);
    logic [1:0] rank;
    rank   = 2'd3 - id;
    vec_of = VEC_BASE + VEC_STRIDE * {14'd0, rank};
  endfunction

  // Synchroniser and per-button debounce
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1   <= '0;
      btn_s2   <= '0;
      db_level <= '0;
      db_prev  <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      btn_s1  <= btn_raw;
      btn_s2  <= btn_s1;
      db_prev <= db_level;
      for (int i = 0; i < 4; i++) begin
        if (btn_s2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_level[i] <= btn_s2[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  assign press    = db_level & ~db_prev;
  assign eligible = pending & int_mask;

  // Arbitration / handshake FSM
  always_comb begin
    state_nxt = state;
    req_nxt   = int_req;
    svc_nxt   = in_service;
    id_nxt    = int_id;
    vec_nxt   = int_vec;
    clr       = '0;
    case (state)
      IDLE: begin
        if (|eligible) begin
          id_nxt    = top_bit(eligible);
          vec_nxt   = vec_of(id_nxt);
          req_nxt   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (int_ack) begin
          req_nxt     = 1'b0;
          svc_nxt     = 1'b1;
          clr[int_id] = 1'b1;
          state_nxt   = SERVICE;
        end
      end
      SERVICE: begin
        if (int_ret) begin
          svc_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A new press on the same edge as its ack keeps the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      int_req    <= 1'b0;
      int_vec    <= '0;
      int_id     <= '0;
      in_service <= 1'b0;
      pending    <= '0;
    end else begin
      state      <= state_nxt;
      int_req    <= req_nxt;
      int_vec    <= vec_nxt;
      int_id     <= id_nxt;
      in_service <= svc_nxt;
      pending    <= (pending & ~clr) | press;
    end
  end

endmodule

// File: tb/tb_button_int_ctrl.sv
// Directed bench for button_int_ctrl with a request scoreboard (DEBOUNCE_CYCLES=4).
module tb_button_int_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  btn_raw;
  logic [3:0]  int_mask;
  logic        int_ack;
  logic        int_ret;
  logic        int_req;
  logic [15:0] int_vec;
  logic [1:0]  int_id;
  logic        in_service;
  logic [3:0]  pending;

  typedef struct {
    logic [15:0] vec;
    logic [1:0]  id;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  button_int_ctrl #(
    .DB_W(16), .DEBOUNCE_CYCLES(4), .VEC_BASE(16'h0f80), .VEC_STRIDE(16'h0020)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .int_mask(int_mask),
    .int_ack(int_ack), .int_ret(int_ret), .int_req(int_req), .int_vec(int_vec),
    .int_id(int_id), .in_service(in_service), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] vec, input logic [1:0] id);
    exp_t e;
    e.vec = vec;
    e.id  = id;
    sb.push_back(e);
  endtask

  // Wait (bounded) for int_req, then compare against the oldest expected request.
  task automatic wait_req(input string tag, input int max);
    exp_t e;
    int   n = 0;
    while (int_req !== 1'b1 && n < max) begin
      tick(1);
      n++;
    end
    chk({tag, "_req"}, {15'd0, int_req}, 16'd1);
    chk({tag, "_sb"}, {15'd0, sb.size() > 0}, 16'd1);
    if (int_req === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_vec"}, int_vec, e.vec);
      chk({tag, "_id"}, {14'd0, int_id}, {14'd0, e.id});
    end
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
  endtask

  task automatic pulse_ret();
    int_ret = 1'b1;
    tick(1);
    int_ret = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, {15'd0, int_req}, 16'd0);
    chk({tag, "_vec"}, int_vec, 16'd0);
    chk({tag, "_id"}, {14'd0, int_id}, 16'd0);
    chk({tag, "_svc"}, {15'd0, in_service}, 16'd0);
    chk({tag, "_pend"}, {12'd0, pending}, 16'd0);
  endtask

  initial begin
    rst = 1'b1; btn_raw = '0; int_mask = 4'hf; int_ack = 1'b0; int_ret = 1'b0;
    tick(2);
    chk_zero("reset");
    rst = 1'b0;
    tick(2);

    // Press btn 1 and hold: request exactly 7 edges after the first sampling edge.
    btn_raw = 4'b0010;
    push(16'h0fc0, 2'd1);
    tick(7);
    chk("t1_req_early", {15'd0, int_req}, 16'd0);
    chk("t1_pend_early", {12'd0, pending}, 16'h0002);
    tick(1);
    chk("t1_pend", {12'd0, pending}, 16'h0002);
    wait_req("t1", 0);
    pulse_ack();
    chk("t1_svc", {15'd0, in_service}, 16'd1);
    chk("t1_req_off", {15'd0, int_req}, 16'd0);
    chk("t1_pend_clr", {12'd0, pending}, 16'd0);
    btn_raw = 4'b0000;
    pulse_ret();
    chk("t1_svc_off", {15'd0, in_service}, 16'd0);
    tick(12);

    // 3-cycle glitch on btn 0 is rejected.
    btn_raw = 4'b0001;
    tick(3);
    btn_raw = 4'b0000;
    tick(12);
    chk("t2_pend", {12'd0, pending}, 16'd0);
    chk("t2_req", {15'd0, int_req}, 16'd0);

    // Simultaneous btn 0 and btn 3: btn 3 first, request held through mask change.
    btn_raw = 4'b1001;
    push(16'h0f80, 2'd3);
    push(16'h0fe0, 2'd0);
    wait_req("t3a", 20);
    chk("t3_pend_both", {12'd0, pending}, 16'h0009);
    int_mask = 4'h0;
    tick(2);
    chk("t3_hold_req", {15'd0, int_req}, 16'd1);
    chk("t3_hold_vec", int_vec, 16'h0f80);
    int_mask = 4'hf;
    pulse_ack();
    chk("t3_pend_after_ack", {12'd0, pending}, 16'h0001);
    btn_raw = 4'b0000;
    pulse_ret();
    wait_req("t3b", 3);
    pulse_ack();
    pulse_ret();
    chk("t3_pend_end", {12'd0, pending}, 16'd0);
    tick(12);

    // Press during SERVICE stays pending; request follows one idle cycle after RET.
    btn_raw = 4'b0001;
    push(16'h0fe0, 2'd0);
    wait_req("t4a", 20);
    pulse_ack();
    btn_raw = 4'b0101;
    push(16'h0fa0, 2'd2);
    tick(12);
    chk("t4_pend", {12'd0, pending}, 16'h0004);
    chk("t4_no_req", {15'd0, int_req}, 16'd0);
    chk("t4_svc", {15'd0, in_service}, 16'd1);
    pulse_ret();
    chk("t4_idle_gap", {15'd0, int_req}, 16'd0);
    tick(1);
    wait_req("t4b", 0);
    pulse_ack();
    pulse_ret();
    btn_raw = 4'b0000;
    tick(12);

    // Masked press stays pending until unmasked.
    int_mask = 4'b1110;
    btn_raw  = 4'b0001;
    tick(14);
    chk("t5_pend", {12'd0, pending}, 16'h0001);
    chk("t5_no_req", {15'd0, int_req}, 16'd0);
    int_mask = 4'b1111;
    push(16'h0fe0, 2'd0);
    tick(1);
    wait_req("t5", 0);
    pulse_ack();
    pulse_ret();
    btn_raw = 4'b0000;
    tick(12);

    // Reset in REQ, then in SERVICE; stray ack/ret in IDLE.
    btn_raw = 4'b1000;
    push(16'h0f80, 2'd3);
    wait_req("t6a", 20);
    rst = 1'b1;
    btn_raw = 4'b0000;
    tick(1);
    rst = 1'b0;
    chk_zero("t6_rst_req");
    tick(4);
    btn_raw = 4'b0100;
    push(16'h0fa0, 2'd2);
    wait_req("t6b", 20);
    pulse_ack();
    chk("t6_svc", {15'd0, in_service}, 16'd1);
    rst = 1'b1;
    btn_raw = 4'b0000;
    tick(1);
    rst = 1'b0;
    chk_zero("t6_rst_svc");
    pulse_ack();
    chk_zero("t6_idle_ack");
    pulse_ret();
    chk_zero("t6_idle_ret");
    int_ack = 1'b1;
    int_ret = 1'b1;
    tick(1);
    int_ack = 1'b0;
    int_ret = 1'b0;
    chk_zero("t6_idle_both");
    tick(3);
    chk("sb_empty", sb.size(), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
